jambu_perm_seq: RTL
===================

Name: jambu_perm_seq

Overview:
Round sequencer for the TinyJAMBU keyed permutation. It time-shares one 64-bit funnel-shift unit with taps 27/21/15/06 across the four feedback windows of each 32-step round. A 128-bit state and 128-bit key are loaded on a start handshake, R rounds are iterated, and done is pulsed. It sits beside the scalar ISE as a co-processor-style accelerator.

Parameters:
ROUND_W, 7, width of the round-count input (max 127 rounds = 4064 steps).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted when start && ready
ready  output  1  high in IDLE only
rounds  input  ROUND_W  number of 32-step rounds (P640 = 20, P1024 = 32); sampled on accept
state_in  input  128  initial state; s0 = [31:0] .. s3 = [127:96]; sampled on accept
key  input  128  key; k0 = [31:0] .. k3 = [127:96]; sampled on accept
busy  output  1  high while rounds are executing
done  output  1  one-cycle pulse when the result is valid
state_out  output  128  permuted state; same word order as state_in; held until next accept

Behaviour:
- Reset values: ready = 1, busy = 0, done = 0, state_out = 0, round counter = 0, FSM = IDLE.
- Reset mid-run: any rst cycle aborts immediately, returns to reset values, no done pulse.
- FSM states: IDLE, PH0, PH1, PH2, PH3, FIN.
- IDLE:
  - On start && ready, latch state, key and rounds; clear the round index j.
  - Go to PH0, or to FIN if rounds == 0.
- PH0: funnel-shift op 15 on {s2,s1} gives t1; acc <= s0 ^ t1 ^ k[j mod 4].
- PH1: op 06 on {s3,s2} gives t2; tmp <= t2.
- PH2: op 21 on {s3,s2}; acc <= acc ^ ~(tmp & result).
- PH3: op 27 on {s3,s2}; fb = acc ^ result.
  - State shifts: s0 <= s1, s1 <= s2, s2 <= s3, s3 <= fb; j <= j + 1.
  - Go to PH0 if j + 1 < rounds, else FIN.
- Funnel-shift op select:
  - One-hot, exactly one select high in PH0–PH3, all low in IDLE and FIN.
  - Operand order is {hi = rs2, lo = rs1}; the result is the low 32 bits of the 64-bit rotate right.
- FIN:
  - state_out <= state; done = 1 for this cycle only; busy = 0.
  - Next cycle returns to IDLE with ready = 1.
- Latency: accept cycle to done = 4*rounds + 1 cycles; rounds = 0 gives done one cycle after accept with state unchanged.
- busy is high in PH0–PH3; ready is low from the cycle after accept until FIN completes.
- start outside IDLE is ignored; it is not queued.
- Input changes after accept have no effect on the run in progress.
- Key index wrap: j mod 4 uses j[1:0]; the j counter is ROUND_W wide, and rounds ≤ 2^ROUND_W − 1 cannot overflow it.

Optional Feature:
Macro JAMBU_PERM_FAST_ROUND_EN.
- Defined:
  - Four parallel funnel-shift instances (one per tap) compute fb combinationally.
  - One round per cycle using a single RUN state in place of PH0–PH3.
  - Latency = rounds + 1; all other ports and semantics are identical.
- Undefined: the single shared instance with the 4-cycle phase schedule above.

Decomposition:
- Package jambu_pkg holds:
  - FSM state enum;
  - tap constants 27/21/15/06;
  - round constants P640_ROUNDS = 20 and P1024_ROUNDS = 32;
  - a 4-bit one-hot op-select typedef.
- One sub-module: jambu_fsr_window.
  - Purely combinational 64-bit funnel shift with one-hot tap select.
  - Instantiated once in the default build and four times (selects tied) under the macro.

Test Plan:
- Zero state, zero key, rounds = 1 -> done at accept + 5; state_out = {FFFFFFFF, 00000000, 00000000, 00000000} (s3..s0).
- Zero state, zero key, rounds = 2 -> done at accept + 9; state_out s3..s0 = {FC00001F, FFFFFFFF, 00000000, 00000000}.
- Zero state, key k0 = 12345678, rounds = 1 -> s3 = EDCBA987.
  - Rounds = 5 with k1..k3 distinct -> round 5 feedback uses k0 again (wrap check against a reference model).
- rounds = 0, state_in = 0123…CDEF pattern -> done at accept + 1; state_out equals state_in; start pulsed while busy is ignored.
- rst asserted in PH2 of round 3 -> next cycle ready = 1, busy = 0, no done, state_out = 0; a new start then completes normally.
- Random state/key, rounds = 20 and 32, compared against a software TinyJAMBU P640/P1024 model.
  - Check done exactly once per accept.
  - Check the op select is one-hot in PH states and zero otherwise.

Source files
------------

// File: rtl/jambu_perm_seq_pkg.sv
// Shared types and constants for the TinyJAMBU round sequencer.
// Optional one-round-per-cycle datapath is selected with JAMBU_PERM_FAST_ROUND_EN.
package jambu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH0  = 3'd1,
    ST_PH1  = 3'd2,
    ST_PH2  = 3'd3,
    ST_PH3  = 3'd4,
    ST_FIN  = 3'd5,
    ST_RUN  = 3'd6
  } fsm_state_t;

  // Feedback tap offsets measured from the low word of each 64-bit window.
  localparam int TAP_27 = 27;
  localparam int TAP_21 = 21;
  localparam int TAP_15 = 15;
  localparam int TAP_06 = 6;

  localparam int P640_ROUNDS  = 20;
  localparam int P1024_ROUNDS = 32;

  typedef logic [3:0] op_sel_t;

  localparam op_sel_t OP_SEL_15 = 4'b0001;
  localparam op_sel_t OP_SEL_06 = 4'b0010;
  localparam op_sel_t OP_SEL_21 = 4'b0100;
  localparam op_sel_t OP_SEL_27 = 4'b1000;

endpackage

// File: rtl/jambu_perm_seq_if.sv
// Request/result bundle of the TinyJAMBU sequencer, plus FSM debug taps.
interface jambu_perm_seq_if
  import jambu_pkg::*;
#(
  parameter int ROUND_W = 7
) ();

  // Handshake: a request is accepted on a rising clk edge where start && ready;
  // rounds/state_in/key are sampled only on that edge. done pulses for one
  // cycle when state_out becomes valid, and state_out holds until the next accept.
  logic               start;
  logic               ready;
  logic [ROUND_W-1:0] rounds;
  logic [127:0]       state_in;
  logic [127:0]       key;
  logic               busy;
  logic               done;
  logic [127:0]       state_out;
  fsm_state_t         dbg_state;
  op_sel_t            dbg_sel;

  modport master (
    output start, rounds, state_in, key,
    input  ready, busy, done, state_out, dbg_state, dbg_sel
  );

  modport slave (
    input  start, rounds, state_in, key,
    output ready, busy, done, state_out, dbg_state, dbg_sel
  );

endinterface

// File: rtl/jambu_fsr_window.sv
// Combinational 64-bit funnel shift {hi,lo} >> tap, returning the low 32 bits.
module jambu_fsr_window
  import jambu_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  op_sel_t     sel,
  output logic [31:0] res
);

  logic [63:0] cat;
  assign cat = {hi, lo};

  always_comb begin
    res = '0;
    unique case (sel)
      OP_SEL_15: res = cat[TAP_15 +: 32];
      OP_SEL_06: res = cat[TAP_06 +: 32];
      OP_SEL_21: res = cat[TAP_21 +: 32];
      OP_SEL_27: res = cat[TAP_27 +: 32];
      default:   res = '0;
    endcase
  end

endmodule

// File: rtl/jambu_perm_seq.sv
// TinyJAMBU keyed-permutation round sequencer (32 steps per round).
// Default: one shared funnel-shift window over four phases; JAMBU_PERM_FAST_ROUND_EN: one round per cycle.
module jambu_perm_seq
  import jambu_pkg::*;
#(
  parameter int ROUND_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  jambu_perm_seq_if.slave  bus
);

  fsm_state_t         fsm;
  logic [31:0]        s [4];
  logic [31:0]        k [4];
  logic [ROUND_W-1:0] rounds_q;
  logic [ROUND_W-1:0] j;
  logic [ROUND_W-1:0] j_nxt;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic [127:0]       state_out_q;
  logic [31:0]        fb;
  op_sel_t            sel;

  assign j_nxt = j + 1'b1;

`ifdef JAMBU_PERM_FAST_ROUND_EN
  logic [31:0] w15, w06, w21, w27;

  // All four taps run every cycle, so no phase select is active.
  assign sel = '0;

  jambu_fsr_window u_w15 (.hi(s[2]), .lo(s[1]), .sel(OP_SEL_15), .res(w15));
  jambu_fsr_window u_w06 (.hi(s[3]), .lo(s[2]), .sel(OP_SEL_06), .res(w06));
  jambu_fsr_window u_w21 (.hi(s[3]), .lo(s[2]), .sel(OP_SEL_21), .res(w21));
  jambu_fsr_window u_w27 (.hi(s[3]), .lo(s[2]), .sel(OP_SEL_27), .res(w27));

  assign fb = s[0] ^ w15 ^ k[j[1:0]] ^ ~(w06 & w21) ^ w27;
`else
  logic [31:0] acc;
  logic [31:0] tmp;
  logic [31:0] win_hi;
  logic [31:0] win_lo;
  logic [31:0] win;

  always_comb begin
    sel = '0;
    unique case (fsm)
      ST_PH0:  sel = OP_SEL_15;
      ST_PH1:  sel = OP_SEL_06;
      ST_PH2:  sel = OP_SEL_21;
      ST_PH3:  sel = OP_SEL_27;
      default: sel = '0;
    endcase
  end

  // Only the t1 tap reads {s2,s1}; the other three share the {s3,s2} window.
  assign win_hi = (fsm == ST_PH0) ? s[2] : s[3];
  assign win_lo = (fsm == ST_PH0) ? s[1] : s[2];

  jambu_fsr_window u_win (.hi(win_hi), .lo(win_lo), .sel(sel), .res(win));

  assign fb = acc ^ win;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        s[i] <= '0;
        k[i] <= '0;
      end
      rounds_q    <= '0;
      j           <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      state_out_q <= '0;
`ifndef JAMBU_PERM_FAST_ROUND_EN
      acc         <= '0;
      tmp         <= '0;
`endif
    end else begin
      unique case (fsm)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start && ready_q) begin
            for (int i = 0; i < 4; i++) begin
              s[i] <= bus.state_in[32*i +: 32];
              k[i] <= bus.key[32*i +: 32];
            end
            rounds_q <= bus.rounds;
            j        <= '0;
            ready_q  <= 1'b0;
            if (bus.rounds == '0) begin
              fsm         <= ST_FIN;
              done_q      <= 1'b1;
              state_out_q <= bus.state_in;
            end else begin
              busy_q <= 1'b1;
`ifdef JAMBU_PERM_FAST_ROUND_EN
              fsm    <= ST_RUN;
`else
              fsm    <= ST_PH0;
`endif
            end
          end
        end
`ifdef JAMBU_PERM_FAST_ROUND_EN
        ST_RUN: begin
          s[0] <= s[1];
          s[1] <= s[2];
          s[2] <= s[3];
          s[3] <= fb;
          j    <= j_nxt;
          if (j_nxt >= rounds_q) begin
            fsm         <= ST_FIN;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_out_q <= {fb, s[3], s[2], s[1]};
          end
        end
`else
        ST_PH0: begin
          acc <= s[0] ^ win ^ k[j[1:0]];
          fsm <= ST_PH1;
        end
        ST_PH1: begin
          tmp <= win;
          fsm <= ST_PH2;
        end
        ST_PH2: begin
          acc <= acc ^ ~(tmp & win);
          fsm <= ST_PH3;
        end
        ST_PH3: begin
          s[0] <= s[1];
          s[1] <= s[2];
          s[2] <= s[3];
          s[3] <= fb;
          j    <= j_nxt;
          if (j_nxt < rounds_q) begin
            fsm <= ST_PH0;
          end else begin
            fsm         <= ST_FIN;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_out_q <= {fb, s[3], s[2], s[1]};
          end
        end
`endif
        ST_FIN: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          fsm     <= ST_IDLE;
        end
        default: begin
          fsm     <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_out = state_out_q;
  assign bus.dbg_state = fsm;
  assign bus.dbg_sel   = sel;

endmodule
